// File: rtl/pe_pkg.sv
// Shared PE definitions: register-file geometry, write-back bundle,
// and helpers used by the port arbiters.
package pe_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  function automatic int onehot_to_idx(input logic [7:0] oh);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) k = i;
    end
    return k;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, search
// starts at the pointer and the pointer advances past the winner.
module rr_arbiter
  import pe_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;

  // First requester at or after the pointer, wrapping, wins
  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[j]) begin
        w_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Pointer moves to one past the winner; holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept && w_found) begin
      r_ptr <= PTR_W'((onehot_to_idx(8'(w_grant)) + 1) % NUM_REQ);
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: round-robin grant between write-back
// requesters, registered write strobe/index/data and an in-flight mask.
module wb_port_arbiter
  import pe_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = XLEN,
  parameter int IDX_W   = REG_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(2**IDX_W)-1:0]     busy_mask
);

  localparam int NREG = 2 ** IDX_W;

  logic               w_accept;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_rd;
  logic [DATA_W-1:0]  w_data;
  logic               w_we;
  logic [NREG-1:0]    w_set;
  logic [NREG-1:0]    w_clr;

  logic               r_wr_en;
  logic [IDX_W-1:0]   r_wr_sel;
  logic [DATA_W-1:0]  r_wr_data;
  logic [NREG-1:0]    r_busy;

  assign w_accept = ~wb_stall & ~rst;
  assign w_req    = req_valid & {NUM_REQ{w_accept}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // AND-OR mux of the granted requester's index and data
  always_comb begin
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_rd   = w_rd   | req_rd[i*IDX_W +: IDX_W];
        w_data = w_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 is hardwired: its handshake completes but nothing is written
  always_comb begin
    w_we  = (|w_grant) && (w_rd != '0);
    w_set = w_we    ? (NREG'(1) << w_rd)     : '0;
    w_clr = r_wr_en ? (NREG'(1) << r_wr_sel) : '0;
  end

  // Output stage: strobe every cycle, index/data only on a real write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_we;
      if (w_we) begin
        r_wr_sel  <= w_rd;
        r_wr_data <= w_data;
      end
    end
  end

  // In-flight mask: set on grant, cleared after commit, set beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign req_ready = w_grant;
  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_data   = r_wr_data;
  assign busy_mask = r_busy;

endmodule
